fb_write_sched: RTL and testbench
=================================

Name: fb_write_sched

Overview:
- Schedules all writes into the 12-bit framebuffer write port (sys_clk side).
- Three requesters share the port: background scroll blitter (BG), player-ship sprite (SPR), bullet renderer (BLT).
- Sequences each frame as a BG pass followed by an object pass, then flips the display buffer on the next frame start.
- Computes the linear write address from (x,y) and owns the display/draw buffer select.

Parameters:
- FB_W, 320, framebuffer width in pixels
- FB_H, 240, framebuffer height in pixels
- ADDR_W, 17, width of the per-buffer linear address (must satisfy 2^ADDR_W >= FB_W*FB_H)
- DATA_W, 12, pixel width, {R[3:0],G[3:0],B[3:0]}

Ports:
- sys_clk in 1: system clock; all logic on its rising edge
- Reset in 1: synchronous, active-high reset
- frame_start in 1: one-cycle pulse, already synchronised to sys_clk (vsync start)
- bg_req in 1: BG pixel valid
- bg_x in 9: BG pixel x
- bg_y in 9: BG pixel y
- bg_data in DATA_W: BG pixel colour
- bg_last in 1: marks the final BG pixel of the pass
- bg_gnt out 1: BG pixel accepted this cycle
- spr_req in 1: SPR pixel valid
- spr_x in 9, spr_y in 9, spr_data in DATA_W: SPR pixel position and colour
- spr_done in 1: SPR has no more pixels this frame (level)
- spr_gnt out 1: SPR pixel accepted this cycle
- blt_req in 1: BLT pixel valid
- blt_x in 9, blt_y in 9, blt_data in DATA_W: BLT pixel position and colour
- blt_done in 1: BLT has no more pixels this frame (level)
- blt_gnt out 1: BLT pixel accepted this cycle
- fb_we out 1: framebuffer write enable
- fb_addr out ADDR_W+1: {draw_buf, y*FB_W+x}
- fb_data out DATA_W: write data
- disp_buf out 1: buffer the VGA read side scans
- busy out 1: high when state is not IDLE or WAIT_FLIP
- drop_cnt out 8: frames where frame_start arrived before the object pass finished; saturates at 255

Behaviour:
- Reset values: state IDLE, all gnt 0, fb_we 0, fb_addr 0, fb_data 0, disp_buf 0, draw_buf 1, drop_cnt 0, rr_ptr points to SPR. Reset mid-pass abandons the pass immediately, with no further writes.
- IDLE: on frame_start, go to BG_PASS.
- BG_PASS: bg_gnt = bg_req (combinational); SPR and BLT gnt are 0. An accepted pixel with bg_last=1 moves the FSM to OBJ_PASS on the next cycle.
- OBJ_PASS: round-robin arbitration between SPR and BLT.
  - Single requester: it is granted.
  - Both requesting: the one rr_ptr points to is granted, and rr_ptr moves to the other.
  - At most one gnt high per cycle; bg_gnt is 0.
  - When spr_done and blt_done are both high and neither req is high: go to WAIT_FLIP.
- WAIT_FLIP: on frame_start, toggle disp_buf and draw_buf (always complementary), then go to BG_PASS in the same edge.
- Late frame: frame_start in BG_PASS or OBJ_PASS means the frame is late.
  - drop_cnt increments (saturating at 255); no buffer flip.
  - The FSM restarts BG_PASS, and the screen keeps showing the previous complete buffer.
- Handshake: a pixel transfers when req and gnt are both high in the same cycle. The requester holds x, y, data while req=1 and gnt=0.
- Write pipeline: one register stage. A transfer in cycle N produces fb_we=1 in cycle N+1, with:
  - fb_addr = {draw_buf, y*FB_W + x}, computed at full width then truncated to ADDR_W;
  - fb_data = pixel of the transfer.
  - fb_we is 0 in every cycle without a preceding transfer.
- Throughput: one write per cycle max; no bubbles between back-to-back transfers.
- frame_start together with an accepted bg_last in the same cycle: frame_start wins (late-frame rule).

Optional Feature:
- Macro FB_BOUNDS_CHECK_EN.
- Defined: a transfer with x >= FB_W or y >= FB_H is still granted (the requester is not stalled), but fb_we stays 0 for it. An out-of-range bg_last still ends BG_PASS.
- Undefined: no check is made, and the address is written as computed and truncated.

Test Plan:
- Reset, frame_start, BG streams (0,0)..(319,239) back-to-back with bg_last on (319,239) -> 76800 writes on consecutive cycles; first write fb_addr={1,0}, last write {1,76799}; FSM reaches OBJ_PASS.
- OBJ_PASS with SPR and BLT both requesting for 6 cycles -> grants alternate SPR,BLT,SPR,BLT,SPR,BLT; never both gnt high.
- Complete the object pass, then frame_start -> disp_buf 0→1, draw_buf 1→0; next BG write at {0,0}.
- frame_start mid OBJ_PASS -> drop_cnt=1, disp_buf unchanged, BG_PASS restarts. 300 consecutive late frames -> drop_cnt=255.
- Reset asserted mid BG_PASS with bg_req high -> next cycle bg_gnt=0, fb_we=0, state IDLE.
- With FB_BOUNDS_CHECK_EN defined: SPR pixel at (320,10) -> spr_gnt=1 but no fb_we pulse. Without the macro: fb_we=1 at addr {draw_buf,3520}.

Source files
------------

// File: rtl/fb_write_sched_if.sv
// Framebuffer write scheduler bus: requester pixel streams, frame timing,
// framebuffer write port and buffer/status outputs. clk and reset stay outside.
interface fb_write_sched_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 12
);
    logic              frame_start;

    logic              bg_req;
    logic [8:0]        bg_x;
    logic [8:0]        bg_y;
    logic [DATA_W-1:0] bg_data;
    logic              bg_last;
    logic              bg_gnt;

    logic              spr_req;
    logic [8:0]        spr_x;
    logic [8:0]        spr_y;
    logic [DATA_W-1:0] spr_data;
    logic              spr_done;
    logic              spr_gnt;

    logic              blt_req;
    logic [8:0]        blt_x;
    logic [8:0]        blt_y;
    logic [DATA_W-1:0] blt_data;
    logic              blt_done;
    logic              blt_gnt;

    logic              fb_we;
    logic [ADDR_W:0]   fb_addr;
    logic [DATA_W-1:0] fb_data;
    logic              disp_buf;
    logic              busy;
    logic [7:0]        drop_cnt;

    // Scheduler side
    modport slave (
        input  frame_start,
        input  bg_req, bg_x, bg_y, bg_data, bg_last,
        output bg_gnt,
        input  spr_req, spr_x, spr_y, spr_data, spr_done,
        output spr_gnt,
        input  blt_req, blt_x, blt_y, blt_data, blt_done,
        output blt_gnt,
        output fb_we, fb_addr, fb_data, disp_buf, busy, drop_cnt
    );

    // Requester / environment side
    modport master (
        output frame_start,
        output bg_req, bg_x, bg_y, bg_data, bg_last,
        input  bg_gnt,
        output spr_req, spr_x, spr_y, spr_data, spr_done,
        input  spr_gnt,
        output blt_req, blt_x, blt_y, blt_data, blt_done,
        input  blt_gnt,
        input  fb_we, fb_addr, fb_data, disp_buf, busy, drop_cnt
    );
endinterface

// File: rtl/fb_write_sched.sv
// Framebuffer write scheduler: BG pass, then round-robin SPR/BLT object pass,
// then buffer flip on the next frame start. One-stage registered write port.
// Optional macro FB_BOUNDS_CHECK_EN: suppress writes of off-screen pixels
// (the pixel is still accepted so the requester never stalls).
//
// state     | meaning
// IDLE      | after reset, waiting for the first frame_start
// BG_PASS   | background blitter owns the write port
// OBJ_PASS  | sprite and bullet renderers share the port round-robin
// WAIT_FLIP | frame drawn, flip buffers on the next frame_start
module fb_write_sched #(
    parameter int FB_W   = 320,
    parameter int FB_H   = 240,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 12
) (
    input  logic              sys_clk,
    input  logic              Reset,
    fb_write_sched_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, BG_PASS, OBJ_PASS, WAIT_FLIP} state_t;

    localparam logic RR_SPR = 1'b0;
    localparam logic RR_BLT = 1'b1;

    if ((64'(1) << ADDR_W) < 64'(FB_W) * 64'(FB_H)) begin : g_addr_too_narrow
        $error("fb_write_sched: ADDR_W cannot address FB_W*FB_H pixels");
    end

    state_t            state_q, state_d;
    logic              rr_q, rr_d;
    logic              disp_buf_q, disp_buf_d;
    logic [7:0]        drop_q, drop_d;
    logic              fb_we_q, fb_we_d;
    logic [ADDR_W:0]   fb_addr_q, fb_addr_d;
    logic [DATA_W-1:0] fb_data_q, fb_data_d;

    logic              bg_gnt, spr_gnt, blt_gnt, late;
    logic [8:0]        sel_x, sel_y;
    logic [DATA_W-1:0] sel_data;
    logic [ADDR_W-1:0] lin_addr;
    logic              in_range, xfer;

    // Next state, arbitration, late-frame accounting and buffer flip
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        disp_buf_d = disp_buf_q;
        drop_d     = drop_q;
        bg_gnt     = 1'b0;
        spr_gnt    = 1'b0;
        blt_gnt    = 1'b0;
        late       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.frame_start) state_d = BG_PASS;
            end
            BG_PASS: begin
                bg_gnt = bus.bg_req;
                if (bus.frame_start)                state_d = BG_PASS;
                else if (bus.bg_req && bus.bg_last) state_d = OBJ_PASS;
                late = bus.frame_start;
            end
            OBJ_PASS: begin
                if (bus.spr_req && bus.blt_req) begin
                    spr_gnt = (rr_q == RR_SPR);
                    blt_gnt = (rr_q == RR_BLT);
                    rr_d    = ~rr_q;
                end else begin
                    spr_gnt = bus.spr_req;
                    blt_gnt = bus.blt_req;
                end
                if (bus.frame_start)
                    state_d = BG_PASS;
                else if (bus.spr_done && bus.blt_done && !bus.spr_req && !bus.blt_req)
                    state_d = WAIT_FLIP;
                late = bus.frame_start;
            end
            WAIT_FLIP: begin
                if (bus.frame_start) begin
                    disp_buf_d = ~disp_buf_q;
                    state_d    = BG_PASS;
                end
            end
            default: state_d = IDLE;
        endcase
        if (late && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        // No pixel may be accepted while reset is abandoning the pass
        if (Reset) begin
            bg_gnt  = 1'b0;
            spr_gnt = 1'b0;
            blt_gnt = 1'b0;
        end
    end

    // Mux the granted pixel and build the next write-port contents
    always_comb begin
        sel_x    = bus.bg_x;
        sel_y    = bus.bg_y;
        sel_data = bus.bg_data;
        if (spr_gnt) begin
            sel_x    = bus.spr_x;
            sel_y    = bus.spr_y;
            sel_data = bus.spr_data;
        end else if (blt_gnt) begin
            sel_x    = bus.blt_x;
            sel_y    = bus.blt_y;
            sel_data = bus.blt_data;
        end
        // Modulo-2^ADDR_W arithmetic equals full-width compute then truncate
        lin_addr = ADDR_W'(sel_y) * ADDR_W'(FB_W) + ADDR_W'(sel_x);
`ifdef FB_BOUNDS_CHECK_EN
        in_range = (32'(sel_x) < FB_W) && (32'(sel_y) < FB_H);
`else
        in_range = 1'b1;
`endif
        xfer      = bg_gnt || spr_gnt || blt_gnt;
        fb_we_d   = xfer && in_range;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        if (xfer) begin
            fb_addr_d = {~disp_buf_q, lin_addr};
            fb_data_d = sel_data;
        end
    end

    // State and write-port registers, synchronous reset
    always_ff @(posedge sys_clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            rr_q       <= RR_SPR;
            disp_buf_q <= 1'b0;
            drop_q     <= 8'd0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            disp_buf_q <= disp_buf_d;
            drop_q     <= drop_d;
            fb_we_q    <= fb_we_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
        end
    end

    assign bus.bg_gnt   = bg_gnt;
    assign bus.spr_gnt  = spr_gnt;
    assign bus.blt_gnt  = blt_gnt;
    assign bus.fb_we    = fb_we_q;
    assign bus.fb_addr  = fb_addr_q;
    assign bus.fb_data  = fb_data_q;
    assign bus.disp_buf = disp_buf_q;
    assign bus.busy     = (state_q == BG_PASS) || (state_q == OBJ_PASS);
    assign bus.drop_cnt = drop_q;
endmodule

// File: tb/tb_fb_write_sched.sv
// Directed bench for fb_write_sched: full BG pass, round-robin object pass,
// buffer flip, late frames with saturation, mid-pass reset, off-screen pixel.
module tb_fb_write_sched;
    logic sys_clk;
    logic Reset;
    int   n_asserts = 0;
    int   n_fail    = 0;

    fb_write_sched_if #(.ADDR_W(17), .DATA_W(12)) bus();

    fb_write_sched #(.FB_W(320), .FB_H(240), .ADDR_W(17), .DATA_W(12)) dut (
        .sys_clk (sys_clk),
        .Reset   (Reset),
        .bus     (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int bad;
        logic [31:0] first_addr, last_addr;

        Reset = 1'b1;
        bus.frame_start = 0;
        bus.bg_req = 0;  bus.bg_x = 0;  bus.bg_y = 0;  bus.bg_data = 0;  bus.bg_last = 0;
        bus.spr_req = 0; bus.spr_x = 0; bus.spr_y = 0; bus.spr_data = 0; bus.spr_done = 0;
        bus.blt_req = 0; bus.blt_x = 0; bus.blt_y = 0; bus.blt_data = 0; bus.blt_done = 0;
        step();
        step();
        bus.bg_req = 1;
        #1;
        chk("rst_bg_gnt",   32'(bus.bg_gnt),   32'd0);
        chk("rst_fb_we",    32'(bus.fb_we),    32'd0);
        chk("rst_fb_addr",  32'(bus.fb_addr),  32'd0);
        chk("rst_fb_data",  32'(bus.fb_data),  32'd0);
        chk("rst_disp_buf", 32'(bus.disp_buf), 32'd0);
        chk("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        chk("rst_busy",     32'(bus.busy),     32'd0);

        Reset = 1'b0;
        step();
        chk("idle_bg_gnt", 32'(bus.bg_gnt), 32'd0);
        bus.bg_req = 0;

        bus.frame_start = 1;
        step();
        bus.frame_start = 0;
        chk("bg_busy", 32'(bus.busy), 32'd1);

        // Full-screen BG stream, one pixel per cycle
        bad = 0;
        first_addr = '1;
        last_addr  = '1;
        for (int i = 0; i < 76800; i++) begin
            bus.bg_req  = 1;
            bus.bg_x    = 9'(i % 320);
            bus.bg_y    = 9'(i / 320);
            bus.bg_data = 12'(i * 7);
            bus.bg_last = (i == 76799);
            #1;
            if (bus.bg_gnt !== 1'b1) bad++;
            step();
            if (bus.fb_we !== 1'b1 || bus.fb_addr !== {1'b1, 17'(i)} || bus.fb_data !== 12'(i * 7)) bad++;
            if (i == 0)     first_addr = 32'(bus.fb_addr);
            if (i == 76799) last_addr  = 32'(bus.fb_addr);
        end
        bus.bg_req  = 0;
        bus.bg_last = 0;
        chk("bg_stream_errors", 32'(bad), 32'd0);
        chk("bg_first_addr", first_addr, 32'(18'h20000));
        chk("bg_last_addr",  last_addr,  32'(18'h20000 + 18'd76799));

        // Object pass: both requesting -> SPR,BLT,SPR,BLT,SPR,BLT
        bus.spr_x = 5; bus.spr_y = 2; bus.spr_data = 12'hA11;
        bus.blt_x = 7; bus.blt_y = 3; bus.blt_data = 12'hB22;
        bus.spr_req = 1;
        bus.blt_req = 1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_spr_gnt", 32'(bus.spr_gnt), 32'((k % 2) == 0));
            chk("rr_blt_gnt", 32'(bus.blt_gnt), 32'((k % 2) == 1));
            chk("rr_bg_gnt",  32'(bus.bg_gnt),  32'd0);
            step();
            chk("rr_fb_we", 32'(bus.fb_we), 32'd1);
            chk("rr_fb_addr", 32'(bus.fb_addr),
                ((k % 2) == 0) ? 32'(18'h20000 + 18'd645) : 32'(18'h20000 + 18'd967));
            chk("rr_fb_data", 32'(bus.fb_data), ((k % 2) == 0) ? 32'h0A11 : 32'h0B22);
        end
        bus.spr_req = 0;
        bus.blt_req = 0;
        step();
        chk("obj_idle_fb_we", 32'(bus.fb_we), 32'd0);
        chk("obj_busy",       32'(bus.busy),  32'd1);

        // Finish object pass, then flip
        bus.spr_done = 1;
        bus.blt_done = 1;
        step();
        chk("wait_flip_busy", 32'(bus.busy),     32'd0);
        chk("pre_flip_disp",  32'(bus.disp_buf), 32'd0);
        bus.frame_start = 1;
        step();
        bus.frame_start = 0;
        chk("flip_disp_buf", 32'(bus.disp_buf), 32'd1);
        chk("flip_busy",     32'(bus.busy),     32'd1);
        bus.bg_req = 1; bus.bg_x = 0; bus.bg_y = 0; bus.bg_data = 12'h123;
        #1;
        chk("flip_bg_gnt", 32'(bus.bg_gnt), 32'd1);
        step();
        chk("flip_fb_we",   32'(bus.fb_we),   32'd1);
        chk("flip_fb_addr", 32'(bus.fb_addr), 32'd0);
        chk("flip_fb_data", 32'(bus.fb_data), 32'h123);

        // Late frame during OBJ_PASS
        bus.spr_done = 0;
        bus.bg_x = 1; bus.bg_last = 1;
        step();
        bus.bg_req = 0; bus.bg_last = 0;
        bus.frame_start = 1;
        step();
        bus.frame_start = 0;
        chk("late_drop_cnt", 32'(bus.drop_cnt), 32'd1);
        chk("late_disp_buf", 32'(bus.disp_buf), 32'd1);
        chk("late_busy",     32'(bus.busy),     32'd1);
        bus.bg_req = 1; bus.bg_x = 2; bus.bg_y = 0;
        bus.spr_req = 1;
        #1;
        chk("late_bg_gnt",  32'(bus.bg_gnt),  32'd1);
        chk("late_spr_gnt", 32'(bus.spr_gnt), 32'd0);

        // frame_start together with accepted bg_last: stays in BG_PASS
        bus.bg_last = 1;
        bus.frame_start = 1;
        step();
        bus.frame_start = 0;
        bus.bg_last = 0;
        chk("fs_last_drop_cnt", 32'(bus.drop_cnt), 32'd2);
        chk("fs_last_fb_addr",  32'(bus.fb_addr),  32'd2);
        #1;
        chk("fs_last_bg_gnt",  32'(bus.bg_gnt),  32'd1);
        chk("fs_last_spr_gnt", 32'(bus.spr_gnt), 32'd0);
        bus.spr_req = 0;
        bus.bg_req  = 0;

        // 300 more late frames -> saturation
        for (int n = 0; n < 300; n++) begin
            bus.frame_start = 1;
            step();
            bus.frame_start = 0;
            step();
        end
        chk("sat_drop_cnt", 32'(bus.drop_cnt), 32'd255);
        chk("sat_disp_buf", 32'(bus.disp_buf), 32'd1);

        // Reset in the middle of BG_PASS with bg_req high
        bus.bg_req = 1; bus.bg_x = 3; bus.bg_y = 1;
        #1;
        chk("pre_rst_bg_gnt", 32'(bus.bg_gnt), 32'd1);
        Reset = 1'b1;
        #1;
        chk("in_rst_bg_gnt", 32'(bus.bg_gnt), 32'd0);
        step();
        chk("mid_rst_bg_gnt",   32'(bus.bg_gnt),   32'd0);
        chk("mid_rst_fb_we",    32'(bus.fb_we),    32'd0);
        chk("mid_rst_busy",     32'(bus.busy),     32'd0);
        chk("mid_rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        chk("mid_rst_disp_buf", 32'(bus.disp_buf), 32'd0);
        Reset = 1'b0;
        bus.bg_req = 0;
        step();
        chk("post_rst_fb_we", 32'(bus.fb_we), 32'd0);

        // Off-screen sprite pixel at (320,10)
        bus.frame_start = 1;
        step();
        bus.frame_start = 0;
        bus.bg_req = 1; bus.bg_x = 0; bus.bg_y = 0; bus.bg_last = 1;
        step();
        bus.bg_req = 0; bus.bg_last = 0;
        bus.spr_req = 1; bus.spr_x = 320; bus.spr_y = 10; bus.spr_data = 12'h0F0;
        #1;
        chk("oob_spr_gnt", 32'(bus.spr_gnt), 32'd1);
        step();
        bus.spr_req = 0;
`ifdef FB_BOUNDS_CHECK_EN
        chk("oob_fb_we", 32'(bus.fb_we), 32'd0);
`else
        chk("oob_fb_we",   32'(bus.fb_we),   32'd1);
        chk("oob_fb_addr", 32'(bus.fb_addr), 32'(18'h20000 + 18'd3520));
        chk("oob_fb_data", 32'(bus.fb_data), 32'h0F0);
`endif
        step();
        chk("oob_after_fb_we", 32'(bus.fb_we), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
